audio_synthesizer_master: RTL and testbench

//  Note sequencer that drives the control inputs of the audio synthesizer slave (pulse1/2, triangle, noise).

---
 rtl/audio_synthesizer_master_if.sv | 44 ++++
 rtl/audio_synthesizer_master.sv | 163 ++++++++++++++++
 tb/tb_audio_synthesizer_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_synthesizer_master_if.sv
// Control/song-memory bundle between the note sequencer (master) and its
// song ROM plus synthesizer slave controls.
interface audio_synthesizer_master_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [63:0]       rom_data;
  logic              busy;

  logic [31:0]       amplitude_pulse1;
  logic [31:0]       period_pulse1;
  logic [1:0]        duty_cycle_pulse1;
  logic              enable_pulse1;
  logic [31:0]       amplitude_pulse2;
  logic [31:0]       period_pulse2;
  logic [1:0]        duty_cycle_pulse2;
  logic              enable_pulse2;
  logic [31:0]       amplitude_triangle;
  logic [31:0]       period_triangle;
  logic              enable_triangle;
  logic [31:0]       amplitude_noise;
  logic [31:0]       period_noise;
  logic              enable_noise;

  modport master (
    input  start, stop, rom_data,
    output rom_addr, busy,
           amplitude_pulse1, period_pulse1, duty_cycle_pulse1, enable_pulse1,
           amplitude_pulse2, period_pulse2, duty_cycle_pulse2, enable_pulse2,
           amplitude_triangle, period_triangle, enable_triangle,
           amplitude_noise, period_noise, enable_noise
  );

  modport slave (
    output start, stop, rom_data,
    input  rom_addr, busy,
           amplitude_pulse1, period_pulse1, duty_cycle_pulse1, enable_pulse1,
           amplitude_pulse2, period_pulse2, duty_cycle_pulse2, enable_pulse2,
           amplitude_triangle, period_triangle, enable_triangle,
           amplitude_noise, period_noise, enable_noise
  );
endinterface

// File: rtl/audio_synthesizer_master.sv
// Note sequencer: fetches 64-bit event words from a synchronous song ROM and
// drives the pulse1/pulse2/triangle/noise channel controls of the synthesizer.
module audio_synthesizer_master #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TICK_CYCLES = 50000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  audio_synthesizer_master_if.master bus
);
  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CNT_W   = 24;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HOLD} state_t;

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_WAIT = 3'd1;
  localparam logic [2:0] OP_LOOP = 3'd2;
  localparam logic [2:0] OP_END  = 3'd3;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_busy, w_busy_nxt;
  logic [3:0][31:0]   r_amp, w_amp_nxt;
  logic [3:0][31:0]   r_per, w_per_nxt;
  logic [1:0][1:0]    r_duty, w_duty_nxt;
  logic [3:0]         r_en, w_en_nxt;
  logic [CNT_W-1:0]   r_ticks, w_ticks_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;

  // Event word fields
  logic [2:0]        w_op;
  logic [1:0]        w_chan;
  logic              w_en_f;
  logic [1:0]        w_duty_f;
  logic [15:0]       w_amp_f;
  logic [CNT_W-1:0]  w_cnt_f;
  logic [ADDR_W-1:0] w_target;
  logic              w_unused;

  assign w_op     = bus.rom_data[63:61];
  assign w_chan   = bus.rom_data[60:59];
  assign w_en_f   = bus.rom_data[58];
  assign w_duty_f = bus.rom_data[57:56];
  assign w_amp_f  = bus.rom_data[55:40];
  assign w_cnt_f  = bus.rom_data[39:16];
  assign w_target = bus.rom_data[ADDR_W-1:0];
  assign w_unused = ^bus.rom_data[15:0];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_amp   <= '0;
      r_per   <= '0;
      r_duty  <= '0;
      r_en    <= '0;
      r_ticks <= '0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= w_busy_nxt;
      r_amp   <= w_amp_nxt;
      r_per   <= w_per_nxt;
      r_duty  <= w_duty_nxt;
      r_en    <= w_en_nxt;
      r_ticks <= w_ticks_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // Stop overrides everything; otherwise step the fetch/execute/hold sequence
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_busy_nxt  = r_busy;
    w_amp_nxt   = r_amp;
    w_per_nxt   = r_per;
    w_duty_nxt  = r_duty;
    w_en_nxt    = r_en;
    w_ticks_nxt = r_ticks;
    w_presc_nxt = r_presc;

    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_en_nxt    = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
            w_busy_nxt  = 1'b1;
          end
        end
        S_FETCH: w_state_nxt = S_EXEC;
        S_EXEC: begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = r_addr + ADDR_W'(1);
          case (w_op)
            OP_SET: begin
              w_amp_nxt[w_chan] = 32'(w_amp_f);
              w_per_nxt[w_chan] = 32'(w_cnt_f);
              w_en_nxt[w_chan]  = w_en_f;
              if (!w_chan[1]) w_duty_nxt[w_chan[0]] = w_duty_f;
            end
            OP_WAIT: begin
              if (w_cnt_f != '0) begin
                w_state_nxt = S_HOLD;
                w_addr_nxt  = r_addr;
                w_ticks_nxt = w_cnt_f;
                w_presc_nxt = '0;
              end
            end
            OP_LOOP: w_addr_nxt = w_target;
            OP_END: begin
              w_state_nxt = S_IDLE;
              w_addr_nxt  = r_addr;
              w_busy_nxt  = 1'b0;
              w_en_nxt    = '0;
            end
            default: ;
          endcase
        end
        S_HOLD: begin
          // Prescaler divides clocks into ticks; leave after the last tick's final clock
          if (r_presc == PRESC_W'(TICK_CYCLES - 1)) begin
            w_presc_nxt = '0;
            if (r_ticks == CNT_W'(1)) begin
              w_state_nxt = S_FETCH;
              w_addr_nxt  = r_addr + ADDR_W'(1);
            end else begin
              w_ticks_nxt = r_ticks - CNT_W'(1);
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr           = r_addr;
  assign bus.busy               = r_busy;
  assign bus.amplitude_pulse1   = r_amp[0];
  assign bus.period_pulse1      = r_per[0];
  assign bus.duty_cycle_pulse1  = r_duty[0];
  assign bus.enable_pulse1      = r_en[0];
  assign bus.amplitude_pulse2   = r_amp[1];
  assign bus.period_pulse2      = r_per[1];
  assign bus.duty_cycle_pulse2  = r_duty[1];
  assign bus.enable_pulse2      = r_en[1];
  assign bus.amplitude_triangle = r_amp[2];
  assign bus.period_triangle    = r_per[2];
  assign bus.enable_triangle    = r_en[2];
  assign bus.amplitude_noise    = r_amp[3];
  assign bus.period_noise       = r_per[3];
  assign bus.enable_noise       = r_en[3];
endmodule

// File: tb/tb_audio_synthesizer_master.sv
// Bench for audio_synthesizer_master: instruction-timing reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_audio_synthesizer_master;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TICK   = 4;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  audio_synthesizer_master_if #(.ADDR_W(ADDR_W)) bus ();

  audio_synthesizer_master #(.ADDR_W(ADDR_W), .TICK_CYCLES(TICK)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  // Synchronous song ROM: data valid one cycle after the address
  logic [63:0] rom [DEPTH];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  logic [31:0] d_amp [4];
  logic [31:0] d_per [4];
  logic [1:0]  d_duty [2];
  logic [3:0]  d_en;
  assign d_amp[0]  = bus.amplitude_pulse1;
  assign d_amp[1]  = bus.amplitude_pulse2;
  assign d_amp[2]  = bus.amplitude_triangle;
  assign d_amp[3]  = bus.amplitude_noise;
  assign d_per[0]  = bus.period_pulse1;
  assign d_per[1]  = bus.period_pulse2;
  assign d_per[2]  = bus.period_triangle;
  assign d_per[3]  = bus.period_noise;
  assign d_duty[0] = bus.duty_cycle_pulse1;
  assign d_duty[1] = bus.duty_cycle_pulse2;
  assign d_en      = {bus.enable_noise, bus.enable_triangle, bus.enable_pulse2, bus.enable_pulse1};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each instruction takes effect 2 edges after its address
  // is presented; a WAIT of k ticks keeps the address for k*TICK extra edges.
  logic [31:0]       m_amp [4];
  logic [31:0]       m_per [4];
  logic [1:0]        m_duty [2];
  logic [3:0]        m_en;
  logic [ADDR_W-1:0] m_addr;
  logic              m_busy;
  logic              m_hold;
  longint            m_due;
  longint            edge_cnt = 0;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'((int'(a) + 1) % DEPTH);
  endfunction

  task automatic model_step();
    logic [63:0] w;
    int          c;
    int          k;
    edge_cnt++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_amp[i] = '0; m_per[i] = '0; end
      m_duty[0] = '0; m_duty[1] = '0;
      m_en = '0; m_addr = '0; m_busy = 1'b0; m_hold = 1'b0; m_due = 0;
    end else if (bus.stop) begin
      m_busy = 1'b0;
      m_en   = '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1; m_addr = '0; m_hold = 1'b0; m_due = edge_cnt + 2;
      end
    end else if (edge_cnt == m_due) begin
      if (m_hold) begin
        m_hold = 1'b0; m_addr = next_addr(m_addr); m_due = edge_cnt + 2;
      end else begin
        w = rom[m_addr];
        m_due = edge_cnt + 2;
        case (w[63:61])
          3'd0: begin
            c = int'(w[60:59]);
            m_en[c]  = w[58];
            m_amp[c] = {16'h0, w[55:40]};
            m_per[c] = {8'h0, w[39:16]};
            if (c < 2) m_duty[c] = w[57:56];
            m_addr = next_addr(m_addr);
          end
          3'd1: begin
            k = int'(w[39:16]);
            if (k == 0) m_addr = next_addr(m_addr);
            else begin m_hold = 1'b1; m_due = edge_cnt + longint'(k) * longint'(TICK); end
          end
          3'd2: m_addr = w[ADDR_W-1:0];
          3'd3: begin m_busy = 1'b0; m_en = '0; end
          default: m_addr = next_addr(m_addr);
        endcase
      end
    end
  endtask

  task automatic compare();
    check("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
    check("busy", 64'(bus.busy), 64'(m_busy));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("amp%0d", c), 64'(d_amp[c]), 64'(m_amp[c]));
      check($sformatf("per%0d", c), 64'(d_per[c]), 64'(m_per[c]));
      check($sformatf("en%0d", c), 64'(d_en[c]), 64'(m_en[c]));
    end
    for (int c = 0; c < 2; c++) check($sformatf("duty%0d", c), 64'(d_duty[c]), 64'(m_duty[c]));
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  endtask

  function automatic logic [63:0] set_word(input logic [1:0] c, input logic en, input logic [1:0] duty,
                                           input logic [15:0] amp, input logic [23:0] per);
    logic [63:0] w;
    w = '0;
    w[63:61] = 3'd0; w[60:59] = c; w[58] = en; w[57:56] = duty; w[55:40] = amp; w[39:16] = per;
    return w;
  endfunction

  function automatic logic [63:0] op_word(input logic [2:0] op, input logic [23:0] cnt, input logic [15:0] low);
    logic [63:0] w;
    w = '0;
    w[63:61] = op; w[39:16] = cnt; w[15:0] = low;
    return w;
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    int          r;
    w = {$urandom, $urandom};
    r = $urandom_range(0, 99);
    if (r < 45)      w[63:61] = 3'd0;
    else if (r < 60) begin w[63:61] = 3'd1; w[39:16] = 24'($urandom_range(0, 3)); end
    else if (r < 70) w[63:61] = 3'd2;
    else if (r < 75) w[63:61] = 3'd3;
    else             w[63:61] = 3'(4 + $urandom_range(0, 3));
    return w;
  endfunction

  // Callers are always positioned at a negedge
  task automatic pulse(input logic s, input logic p);
    bus.start = s; bus.stop = p;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, input int max, output int n);
    n = 0;
    while (bus.rom_addr !== a && n <= max) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n <= max) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    int r;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = op_word(3'd4, 24'h0, 16'h0);
    fork monitor(); join_none

    #1 rst = 1'b1;
    #1;
    check("reset_addr", 64'(bus.rom_addr), 64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_en", 64'(d_en), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // SET / WAIT 3 / LOOP 0
    rom[0] = set_word(2'd0, 1'b1, 2'd2, 16'h1000, 24'd100);
    rom[1] = op_word(3'd1, 24'd3, 16'h0);
    rom[2] = op_word(3'd2, 24'h0, 16'h0);
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("start_addr", 64'(bus.rom_addr), 64'h0);
    check("start_busy", 64'(bus.busy), 64'h1);
    @(negedge clk);
    check("set_not_yet", 64'(bus.enable_pulse1), 64'h0);
    @(negedge clk);
    check("set_en", 64'(bus.enable_pulse1), 64'h1);
    check("set_amp", 64'(bus.amplitude_pulse1), 64'h1000);
    check("set_per", 64'(bus.period_pulse1), 64'd100);
    check("set_duty", 64'(bus.duty_cycle_pulse1), 64'd2);
    check("set_addr", 64'(bus.rom_addr), 64'h1);
    wait_addr(4'd2, 40, n);
    check("hold_len", 64'(n), 64'd14);
    repeat (2) @(negedge clk);
    check("loop_addr", 64'(bus.rom_addr), 64'h0);
    check("loop_busy", 64'(bus.busy), 64'h1);
    repeat (6) @(negedge clk);
    check("in_hold_addr", 64'(bus.rom_addr), 64'h1);
    pulse(1'b0, 1'b1);
    check("stop_busy", 64'(bus.busy), 64'h0);
    check("stop_en", 64'(d_en), 64'h0);
    check("stop_per_hold", 64'(bus.period_pulse1), 64'd100);
    pulse(1'b1, 1'b1);
    check("start_stop_busy", 64'(bus.busy), 64'h0);
    check("start_stop_addr", 64'(bus.rom_addr), 64'h1);

    // END terminates and a prompt restart replays from 0
    rom[2] = op_word(3'd3, 24'h0, 16'h0);
    pulse(1'b1, 1'b0);
    wait_idle(40, n);
    check("end_len", 64'(n), 64'd18);
    check("end_en", 64'(bus.enable_pulse1), 64'h0);
    check("end_per", 64'(bus.period_pulse1), 64'd100);
    pulse(1'b1, 1'b0);
    check("replay_addr", 64'(bus.rom_addr), 64'h0);
    check("replay_busy", 64'(bus.busy), 64'h1);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1);

    // Reserved-opcode NOPs walk the address space and wrap
    for (int i = 0; i < DEPTH; i++) rom[i] = op_word(3'(4 + $urandom_range(0, 3)), 24'($urandom), 16'($urandom));
    pulse(1'b1, 1'b0);
    check("nop_addr0", 64'(bus.rom_addr), 64'h0);
    repeat (30) @(negedge clk);
    check("nop_addr15", 64'(bus.rom_addr), 64'd15);
    repeat (2) @(negedge clk);
    check("nop_wrap", 64'(bus.rom_addr), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_addr", 64'(bus.rom_addr), 64'h0);
    check("async_rst_busy", 64'(bus.busy), 64'h0);
    check("async_rst_amp", 64'(bus.amplitude_pulse1), 64'h0);
    check("async_rst_per", 64'(bus.period_pulse1), 64'h0);
    check("async_rst_duty", 64'(bus.duty_cycle_pulse1), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random programs with random start/stop traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
      pulse(1'b1, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(20, 200)) begin
        r = $urandom_range(0, 99);
        bus.start = (r < 6) || (r == 99);
        bus.stop  = (r >= 6 && r < 8) || (r == 99);
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      pulse(1'b0, 1'b1);
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
